// File: rtl/peripheral_comunicaciones_rx.sv
// Comunicaciones serial receiver: 16x-oversampled async frames, small byte FIFO, J1 bus registers.
// Define COMUNICACIONES_RX_PARITY_EN to receive 8E1 frames and report parity errors (perr).
module peripheral_comunicaciones_rx #(
    parameter int clkFreq    = 50000000,
    parameter int baudRate   = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        rx,
    output logic        rx_avail
);
    localparam int DIV_RAW = clkFreq / (baudRate * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef COMUNICACIONES_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    logic [TW-1:0] tickCnt_q;
    logic          tick;
    logic          rxMeta_q;
    logic          rxS_q;
    logic [1:0]    syncFill_q;
    logic          armed_q;
    state_t        state_q;
    logic [3:0]    scnt_q;
    logic [2:0]    bcnt_q;
    logic [7:0]    shreg_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          popLevel_q;
    logic          ovr_q;
    logic          ovr_d;
    logic          ferr_q;
    logic          ferr_d;
    logic          perr;

    logic          empty;
    logic          full;
    logic          stopDone;
    logic          pushReq;
    logic          pushDo;
    logic          popLevel;
    logic          popDo;
    logic          clrWr;

    assign tick = (tickCnt_q == TW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tickCnt_q <= '0;
        end else if (tick) begin
            tickCnt_q <= '0;
        end else begin
            tickCnt_q <= tickCnt_q + 1'b1;
        end
    end

    // The synchroniser resets to 1, so armed only trusts rxS_q once real line samples have
    // flushed through both flops; a line held low across reset therefore never arms.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta_q   <= 1'b1;
            rxS_q      <= 1'b1;
            syncFill_q <= '0;
            armed_q    <= 1'b0;
        end else begin
            rxMeta_q   <= rx;
            rxS_q      <= rxMeta_q;
            syncFill_q <= {syncFill_q[0], 1'b1};
            if (syncFill_q[1] && rxS_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
        end else if (tick) begin
            case (state_q)
                IDLE: begin
                    if (armed_q && !rxS_q) begin
                        state_q <= START;
                        scnt_q  <= '0;
                    end
                end
                START: begin
                    if (scnt_q == 4'd7) begin
                        scnt_q <= '0;
                        bcnt_q <= '0;
                        state_q <= rxS_q ? IDLE : DATA;
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (scnt_q == 4'd15) begin
                        scnt_q  <= '0;
                        shreg_q <= {rxS_q, shreg_q[7:1]};
                        if (bcnt_q == 3'd7) begin
`ifdef COMUNICACIONES_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
`ifdef COMUNICACIONES_RX_PARITY_EN
                PARITY: begin
                    if (scnt_q == 4'd15) begin
                        scnt_q  <= '0;
                        state_q <= STOP;
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (scnt_q == 4'd15) begin
                        scnt_q  <= '0;
                        state_q <= rxS_q ? IDLE : BREAK;
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxS_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Push is decoded straight from the stop-bit sample so the byte lands on that same edge.
    assign stopDone = tick && (state_q == STOP) && (scnt_q == 4'd15);
    assign pushReq  = stopDone && rxS_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pushDo   = pushReq && !full;
    assign popLevel = cs && rd && (addr == 4'h0);
    assign popDo    = popLevel && !popLevel_q && !empty;
    assign clrWr    = cs && wr && (addr == 4'h4);

    always_comb begin
        count_d = count_q;
        if (pushDo && !popDo) begin
            count_d = count_q + 1'b1;
        end else if (!pushDo && popDo) begin
            count_d = count_q - 1'b1;
        end
        ovr_d  = (pushReq && full) || (ovr_q && !(clrWr && d_in[0]));
        ferr_d = (stopDone && !rxS_q) || (ferr_q && !(clrWr && d_in[1]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            popLevel_q <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            popLevel_q <= popLevel;
            count_q    <= count_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            if (pushDo) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popDo) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pushDo) begin
            mem_q[wrPtr_q] <= shreg_q;
        end
    end

`ifdef COMUNICACIONES_RX_PARITY_EN
    logic perr_q;
    logic perrSet;
    logic unused_dIn;

    // Even parity: the eight data bits plus the parity bit must XOR to zero.
    assign perrSet = tick && (state_q == PARITY) && (scnt_q == 4'd15) && (^{shreg_q, rxS_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perrSet || (perr_q && !(clrWr && d_in[2]));
        end
    end

    assign perr       = perr_q;
    assign unused_dIn = ^d_in[15:3];
`else
    logic unused_dIn;

    assign perr       = 1'b0;
    assign unused_dIn = ^d_in[15:2];
`endif

    always_comb begin
        d_out = '0;
        case (addr)
            4'h0: begin
                if (!empty) begin
                    d_out = {8'h00, mem_q[rdPtr_q]};
                end
            end
            4'h2: d_out = {11'b0, perr, full, ferr_q, ovr_q, !empty};
            default: d_out = '0;
        endcase
    end

    assign rx_avail = !empty;

endmodule

// File: tb/tb_peripheral_comunicaciones_rx.sv
// Directed bench for peripheral_comunicaciones_rx: table of single frames plus hand-written
// sequences for glitches, breaks, overflow, push/pop collisions, multi-cycle reads and reset.
module tb_peripheral_comunicaciones_rx;
    localparam int BIT_CLKS = 16;
`ifdef COMUNICACIONES_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Negedge (from the start-bit edge) just before the edge that pushes the stop-bit sample.
    localparam int POP_AT = BIT_CLKS * (FRAME_BITS - 1) + 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d_in = '0;
    logic        cs = 1'b0;
    logic [3:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] d_out;
    logic        rx = 1'b1;
    logic        rx_avail;

    logic [15:0] rdData;
    int          vectorsApplied = 0;
    int          miscompares = 0;

    typedef struct {
        logic [7:0]  data;
        logic        stopBit;
        logic [15:0] expStatus;
        logic        expAvail;
        logic [15:0] expRead;
        logic [15:0] expStatusAfter;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    peripheral_comunicaciones_rx #(
        .clkFreq   (1600000),
        .baudRate  (100000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d_in    (d_in),
        .cs      (cs),
        .addr    (addr),
        .rd      (rd),
        .wr      (wr),
        .d_out   (d_out),
        .rx      (rx),
        .rx_avail(rx_avail)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic sendFrameRaw(input logic [7:0] data, input logic stopBit, input int stopClks);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            sendBit(data[i]);
        end
`ifdef COMUNICACIONES_RX_PARITY_EN
        sendBit(^data);
`endif
        rx = stopBit;
        repeat (stopClks) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic stopBit);
        sendFrameRaw(data, stopBit, BIT_CLKS);
    endtask

    task automatic readReg(input logic [3:0] a, output logic [15:0] v);
        cs   = 1'b1;
        rd   = 1'b1;
        addr = a;
        #1 v = d_out;
        @(negedge clk);
        cs   = 1'b0;
        rd   = 1'b0;
        addr = 4'h0;
        @(negedge clk);
    endtask

    task automatic writeReg(input logic [3:0] a, input logic [15:0] data);
        cs   = 1'b1;
        wr   = 1'b1;
        addr = a;
        d_in = data;
        @(negedge clk);
        cs   = 1'b0;
        wr   = 1'b0;
        addr = 4'h0;
        d_in = '0;
        @(negedge clk);
    endtask

    task automatic checkReg(input string name, input logic [3:0] a, input logic [15:0] expected);
        logic [15:0] v;
        readReg(a, v);
        checkOutput(name, v, expected);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        sendFrame(v.data, v.stopBit);
        idle(BIT_CLKS);
        checkReg($sformatf("vec%0d_status", idx), 4'h2, v.expStatus);
        checkOutput($sformatf("vec%0d_rx_avail", idx), {15'b0, rx_avail}, {15'b0, v.expAvail});
        checkReg($sformatf("vec%0d_data", idx), 4'h0, v.expRead);
        checkReg($sformatf("vec%0d_statusAfter", idx), 4'h2, v.expStatusAfter);
    endtask

`ifdef COMUNICACIONES_RX_PARITY_EN
    task automatic sendBadParityFrame(input logic [7:0] data);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            sendBit(data[i]);
        end
        sendBit(~^data);
        sendBit(1'b1);
        rx = 1'b1;
    endtask
`endif

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 16'h0001, 1'b1, 16'h00A5, 16'h0000};
        vecs[1] = '{8'h3C, 1'b0, 16'h0004, 1'b0, 16'h0000, 16'h0004};
        vecs[2] = '{8'h11, 1'b1, 16'h0005, 1'b1, 16'h0011, 16'h0004};
        vecs[3] = '{8'hFF, 1'b1, 16'h0005, 1'b1, 16'h00FF, 16'h0004};
        vecs[4] = '{8'h00, 1'b1, 16'h0005, 1'b1, 16'h0000, 16'h0004};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(4);
        checkOutput("reset_rx_avail", {15'b0, rx_avail}, 16'h0000);
        checkReg("reset_status", 4'h2, 16'h0000);
        checkReg("reset_data", 4'h0, 16'h0000);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], i);
        end
        writeReg(4'h4, 16'h0002);
        checkReg("table_ferr_clear", 4'h2, 16'h0000);

        // Short low glitch must be rejected at the start-bit centre sample.
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        checkReg("glitch_status", 4'h2, 16'h0000);
        checkOutput("glitch_rx_avail", {15'b0, rx_avail}, 16'h0000);
        sendFrame(8'h5A, 1'b1);
        idle(BIT_CLKS);
        checkReg("after_glitch_data", 4'h0, 16'h005A);

        // Framing error followed by a line held low (break).
        sendFrameRaw(8'h3C, 1'b0, BIT_CLKS + 40);
        idle(BIT_CLKS);
        checkReg("break_status", 4'h2, 16'h0004);
        checkOutput("break_rx_avail", {15'b0, rx_avail}, 16'h0000);
        writeReg(4'h2, 16'h0007);
        checkReg("write_other_offset_ignored", 4'h2, 16'h0004);
        sendFrame(8'h11, 1'b1);
        idle(BIT_CLKS);
        checkReg("after_break_status", 4'h2, 16'h0005);
        checkReg("after_break_data", 4'h0, 16'h0011);
        writeReg(4'h4, 16'h0001);
        checkReg("clear_ovr_keeps_ferr", 4'h2, 16'h0004);
        writeReg(4'h4, 16'h0002);
        checkReg("clear_ferr", 4'h2, 16'h0000);

        // Overflow: fifth byte is dropped and the first four are kept in order.
        for (int b = 1; b <= 5; b++) begin
            sendFrame(8'(b), 1'b1);
        end
        idle(BIT_CLKS);
        checkReg("overflow_status", 4'h2, 16'h000B);
        for (int b = 1; b <= 4; b++) begin
            checkReg($sformatf("overflow_data%0d", b), 4'h0, 16'(b));
        end
        checkReg("overflow_drained_data", 4'h0, 16'h0000);
        checkReg("overflow_drained_status", 4'h2, 16'h0002);
        writeReg(4'h4, 16'h0001);
        checkReg("clear_ovr", 4'h2, 16'h0000);

        // Pop on the very edge that pushes 0x23: count must stay at 2.
        sendFrame(8'h21, 1'b1);
        sendFrame(8'h22, 1'b1);
        idle(BIT_CLKS);
        fork
            sendFrame(8'h23, 1'b1);
            begin
                repeat (POP_AT) @(negedge clk);
                readReg(4'h0, rdData);
            end
        join
        checkOutput("pushpop_head", rdData, 16'h0021);
        idle(BIT_CLKS);
        sendFrame(8'h24, 1'b1);
        sendFrame(8'h25, 1'b1);
        idle(BIT_CLKS);
        checkReg("pushpop_full_status", 4'h2, 16'h0009);
        for (int b = 2; b <= 5; b++) begin
            checkReg($sformatf("pushpop_data%0d", b), 4'h0, 16'h0020 + 16'(b));
        end
        checkReg("pushpop_empty_status", 4'h2, 16'h0000);

        // A read strobe held for three cycles pops exactly one byte.
        sendFrame(8'h31, 1'b1);
        sendFrame(8'h32, 1'b1);
        idle(BIT_CLKS);
        cs   = 1'b1;
        rd   = 1'b1;
        addr = 4'h0;
        #1 rdData = d_out;
        checkOutput("longrd_head", rdData, 16'h0031);
        repeat (3) @(negedge clk);
        cs = 1'b0;
        rd = 1'b0;
        @(negedge clk);
        checkReg("longrd_next", 4'h0, 16'h0032);
        checkReg("longrd_status", 4'h2, 16'h0000);

        // Reset mid-frame with the line held low: FIFO empties and no frame starts.
        sendFrame(8'h41, 1'b1);
        idle(BIT_CLKS);
        rx = 1'b0;
        idle(50);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(200);
        checkReg("midreset_status", 4'h2, 16'h0000);
        checkOutput("midreset_rx_avail", {15'b0, rx_avail}, 16'h0000);
        rx = 1'b1;
        idle(BIT_CLKS);
        sendFrame(8'h42, 1'b1);
        idle(BIT_CLKS);
        checkReg("after_midreset_data", 4'h0, 16'h0042);

`ifdef COMUNICACIONES_RX_PARITY_EN
        sendBadParityFrame(8'h07);
        idle(BIT_CLKS);
        checkReg("parity_status", 4'h2, 16'h0011);
        checkReg("parity_data", 4'h0, 16'h0007);
        checkReg("parity_status_after", 4'h2, 16'h0010);
        writeReg(4'h4, 16'h0004);
        checkReg("parity_clear", 4'h2, 16'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
